pattern_burst_generator: RTL and testbench

Parametrised burst test-pattern source for the FIFO/streaming test path. A rising edge on a trigger starts one burst of a configurable number of words. Each word follows one of four patterns: incrementing counter, Galois LFSR, walking one, or constant. Output is a valid/ready stream with backpressure, a last-beat marker and completion/drop status, so the block can feed any FIFO or master under test.

---
 rtl/pattern_gen_pkg.sv | 20 ++
 rtl/pattern_next.sv | 25 ++
 rtl/pattern_burst_generator.sv | 120 ++++++++++++
 tb/tb_pattern_burst_generator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared encodings for the burst pattern generator: pattern modes, FSM states
// and the default Galois feedback mask.
package pattern_gen_pkg;

   typedef enum logic [1:0] {
      MODE_COUNTER = 2'd0,
      MODE_LFSR    = 2'd1,
      MODE_WALK    = 2'd2,
      MODE_CONST   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'hA300_0000;

endpackage

// File: rtl/pattern_next.sv
// Combinational next-word generator: computes the word that follows the
// current one for the selected pattern mode.
module pattern_next
   import pattern_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] cur,
   output logic [DATA_WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (mode)
         MODE_COUNTER: nxt = cur + DATA_WIDTH'(1);
         // Galois form: shift right, fold the feedback mask in when the LSB drops out
         MODE_LFSR:    nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
         MODE_WALK:    nxt = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
         default:      nxt = cur;
      endcase
   end

endmodule

// File: rtl/pattern_burst_generator.sv
// Triggered burst source: one rising trigger edge emits a burst of patterned
// words on a valid/ready stream with last, done and trigger-drop status.
module pattern_burst_generator
   import pattern_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    LEN_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  trigger_in,
   input  logic [1:0]            mode_in,
   input  logic [LEN_WIDTH-1:0]  burst_len_in,
   input  logic [DATA_WIDTH-1:0] seed_in,
   input  logic                  ready_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  last_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  trigger_drop_out
);

   state_t                state;
   logic                  trigger_prev;
   logic                  trig_edge;
   logic [1:0]            mode_r;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [DATA_WIDTH-1:0] seed_r;
   logic [DATA_WIDTH-1:0] first_word;
   logic [DATA_WIDTH-1:0] next_word;

   assign trig_edge = trigger_in && !trigger_prev;

   pattern_next #(
      .DATA_WIDTH (DATA_WIDTH),
      .LFSR_TAPS  (LFSR_TAPS)
   ) u_next (
      .mode (mode_r),
      .cur  (data_out),
      .nxt  (next_word)
   );

   // A zero state would lock the LFSR and leave walking-one with no bit to walk
   always_comb begin
      first_word = seed_r;
      if ((mode_r == MODE_LFSR || mode_r == MODE_WALK) && seed_r == '0)
         first_word = DATA_WIDTH'(1);
   end

   // Burst configuration is captured only when a trigger is accepted
   always_ff @(posedge clk_in) begin
      if (state == ST_IDLE && trig_edge) begin
         mode_r <= mode_in;
         len_r  <= burst_len_in;
         seed_r <= seed_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= ST_IDLE;
         trigger_prev     <= 1'b0;
         remaining        <= '0;
         data_out         <= '0;
         valid_out        <= 1'b0;
         last_out         <= 1'b0;
         busy_out         <= 1'b0;
         done_out         <= 1'b0;
         trigger_drop_out <= 1'b0;
      end else begin
         trigger_prev     <= trigger_in;
         done_out         <= 1'b0;
         trigger_drop_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig_edge) begin
                  busy_out <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               trigger_drop_out <= trig_edge;
               if (len_r == '0) begin
                  done_out <= 1'b1;
                  busy_out <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  data_out  <= first_word;
                  valid_out <= 1'b1;
                  last_out  <= (len_r == LEN_WIDTH'(1));
                  remaining <= len_r;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               trigger_drop_out <= trig_edge;
               if (valid_out && ready_in) begin
                  if (remaining > LEN_WIDTH'(1)) begin
                     data_out  <= next_word;
                     remaining <= remaining - LEN_WIDTH'(1);
                     last_out  <= (remaining == LEN_WIDTH'(2));
                  end else begin
                     valid_out <= 1'b0;
                     last_out  <= 1'b0;
                     done_out  <= 1'b1;
                     busy_out  <= 1'b0;
                     remaining <= '0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_burst_generator.sv
// Directed bench for pattern_burst_generator and the standalone pattern_next.
`timescale 1ns/1ps
module tb_pattern_burst_generator;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        trigger_in;
   logic [1:0]  mode_in;
   logic [15:0] burst_len_in;
   logic [31:0] seed_in;
   logic        ready_in;
   logic [31:0] data_out;
   logic        valid_out, last_out, busy_out, done_out, trigger_drop_out;

   logic [1:0]  nx_mode;
   logic [31:0] nx_cur, nx_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   pattern_burst_generator #(
      .DATA_WIDTH (32),
      .LEN_WIDTH  (16),
      .LFSR_TAPS  (32'hA300_0000)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .trigger_in       (trigger_in),
      .mode_in          (mode_in),
      .burst_len_in     (burst_len_in),
      .seed_in          (seed_in),
      .ready_in         (ready_in),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .last_out         (last_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .trigger_drop_out (trigger_drop_out)
   );

   pattern_next #(
      .DATA_WIDTH (32),
      .LFSR_TAPS  (32'hA300_0000)
   ) u_nx (
      .mode (nx_mode),
      .cur  (nx_cur),
      .nxt  (nx_out)
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Requests a burst; the trigger edge is sampled at the clock edge inside.
   task automatic fire(input logic [1:0] m, input logic [15:0] l,
                       input logic [31:0] s, input bit hold);
      mode_in      = m;
      burst_len_in = l;
      seed_in      = s;
      trigger_in   = 1'b1;
      step();
      if (!hold) trigger_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; trigger_in = 1'b0; mode_in = 2'd0; burst_len_in = '0;
      seed_in = '0; ready_in = 1'b1;
      step(); step();
      rst_in = 1'b0;
      n_checks++;
      if ({data_out, valid_out, last_out, busy_out, done_out, trigger_drop_out} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: data=%h v=%b l=%b b=%b d=%b drop=%b, expected all zero",
                  data_out, valid_out, last_out, busy_out, done_out, trigger_drop_out);
      end
      step();
   endtask

   task automatic test_next();
      logic [1:0]  m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [31:0] c [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_1234};
      logic [31:0] e [4] = '{32'h0000_0000, 32'hA300_0000, 32'h0000_0001, 32'h0000_1234};
      for (int i = 0; i < 4; i++) begin
         nx_mode = m[i]; nx_cur = c[i];
         #1;
         n_checks++;
         if (nx_out !== e[i]) begin
            n_fail++;
            $display("FAIL next_mode%0d: got %h expected %h", i, nx_out, e[i]);
         end
      end
   endtask

   task automatic test_counter();
      logic [31:0] e [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      ready_in = 1'b1;
      fire(2'd0, 16'd4, 32'hFFFF_FFFE, 1'b0);
      n_checks++;
      if (busy_out !== 1'b1 || valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt_load: busy=%b valid=%b expected busy=1 valid=0", busy_out, valid_out);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== e[i] || last_out !== (i == 3)) begin
            n_fail++;
            $display("FAIL cnt_word%0d: v=%b data=%h last=%b expected v=1 data=%h last=%b",
                     i, valid_out, data_out, last_out, e[i], (i == 3));
         end
      end
      step();
      n_checks++;
      if (valid_out !== 1'b0 || done_out !== 1'b1 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt_done: v=%b done=%b busy=%b expected 0 1 0", valid_out, done_out, busy_out);
      end
      step();
      n_checks++;
      if (done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt_done_pulse: done=%b expected 0", done_out);
      end
   endtask

   task automatic test_lfsr();
      logic [31:0] e [3] = '{32'h0000_0001, 32'hA300_0000, 32'h5180_0000};
      ready_in = 1'b1;
      fire(2'd1, 16'd3, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== e[i] || last_out !== (i == 2)) begin
            n_fail++;
            $display("FAIL lfsr_word%0d: v=%b data=%h last=%b expected v=1 data=%h last=%b",
                     i, valid_out, data_out, last_out, e[i], (i == 2));
         end
      end
      step();
      n_checks++;
      if (valid_out !== 1'b0 || done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL lfsr_done: v=%b done=%b expected 0 1", valid_out, done_out);
      end
   endtask

   task automatic test_walk_backpressure();
      logic [31:0] e [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
      int  idx = 0;
      int  cyc = 0;
      bit  rdy = 1'b1;
      ready_in = 1'b0;
      fire(2'd2, 16'd3, 32'h8000_0000, 1'b0);
      step();
      while (idx < 3 && cyc < 20) begin
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== e[idx] || last_out !== (idx == 2)) begin
            n_fail++;
            $display("FAIL walk_cyc%0d: v=%b data=%h last=%b expected v=1 data=%h last=%b",
                     cyc, valid_out, data_out, last_out, e[idx], (idx == 2));
         end
         ready_in = rdy;
         step();
         if (rdy) idx++;
         rdy = !rdy;
         cyc++;
      end
      ready_in = 1'b1;
      n_checks++;
      if (valid_out !== 1'b0 || done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL walk_done: v=%b done=%b expected 0 1 after 3 transfers", valid_out, done_out);
      end
      step();
      n_checks++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL walk_idle: v=%b busy=%b expected 0 0", valid_out, busy_out);
      end
   endtask

   task automatic test_zero_len();
      ready_in = 1'b1;
      fire(2'd0, 16'd0, 32'h1234, 1'b0);
      n_checks++;
      if (busy_out !== 1'b1 || valid_out !== 1'b0 || done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_load: busy=%b v=%b done=%b expected 1 0 0", busy_out, valid_out, done_out);
      end
      step();
      n_checks++;
      if (busy_out !== 1'b0 || valid_out !== 1'b0 || done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: busy=%b v=%b done=%b expected 0 0 1", busy_out, valid_out, done_out);
      end
      step();
      n_checks++;
      if (done_out !== 1'b0 || valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_after: done=%b v=%b expected 0 0", done_out, valid_out);
      end
   endtask

   // Mid-burst re-pulse (including one on the final transfer), then a held trigger.
   task automatic test_drop();
      int words, drops, dones;
      for (int pass = 0; pass < 2; pass++) begin
         words = 0; drops = 0; dones = 0;
         ready_in = 1'b1;
         fire(2'd0, 16'd8, 32'h0, pass == 1);
         for (int c = 0; c < 12; c++) begin
            if (pass == 0) trigger_in = (c == 2 || c == 8);
            step();
            if (valid_out) begin
               n_checks++;
               if (data_out !== 32'(words) || last_out !== (words == 7)) begin
                  n_fail++;
                  $display("FAIL drop%0d_word%0d: data=%h last=%b expected data=%h last=%b",
                           pass, words, data_out, last_out, 32'(words), (words == 7));
               end
               words++;
            end
            if (trigger_drop_out) drops++;
            if (done_out) dones++;
         end
         n_checks++;
         if (words != 8 || drops != (pass == 0 ? 2 : 0) || dones != 1 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drop%0d_summary: words=%0d drops=%0d dones=%0d busy=%b expected 8 %0d 1 0",
                     pass, words, drops, dones, busy_out, (pass == 0 ? 2 : 0));
         end
         trigger_in = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e [3] = '{32'h1, 32'h2, 32'h4};
      ready_in = 1'b1;
      fire(2'd0, 16'd10, 32'd100, 1'b0);
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 32'd104) begin
         n_fail++;
         $display("FAIL rstmid_word5: v=%b data=%h expected v=1 data=%h", valid_out, data_out, 32'd104);
      end
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      n_checks++;
      if ({data_out, valid_out, last_out, busy_out, done_out, trigger_drop_out} !== 37'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: data=%h v=%b l=%b b=%b d=%b drop=%b, expected all zero",
                  data_out, valid_out, last_out, busy_out, done_out, trigger_drop_out);
      end
      step();
      n_checks++;
      if (done_out !== 1'b0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_nodone: done=%b busy=%b expected 0 0", done_out, busy_out);
      end
      fire(2'd2, 16'd3, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== e[i] || last_out !== (i == 2)) begin
            n_fail++;
            $display("FAIL rstmid_new%0d: v=%b data=%h last=%b expected v=1 data=%h last=%b",
                     i, valid_out, data_out, last_out, e[i], (i == 2));
         end
      end
      step();
      n_checks++;
      if (done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_newdone: done=%b expected 1", done_out);
      end
   endtask

   // Second trigger edge lands in the done_out cycle and must be accepted.
   task automatic test_back_to_back();
      ready_in = 1'b1;
      fire(2'd0, 16'd2, 32'd10, 1'b0);
      step(); step(); step();
      n_checks++;
      if (done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done1: done=%b expected 1", done_out);
      end
      fire(2'd3, 16'd1, 32'd55, 1'b0);
      n_checks++;
      if (busy_out !== 1'b1 || trigger_drop_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b drop=%b expected 1 0", busy_out, trigger_drop_out);
      end
      step();
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 32'd55 || last_out !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_word: v=%b data=%h last=%b expected 1 %h 1", valid_out, data_out, last_out, 32'd55);
      end
      step();
      n_checks++;
      if (done_out !== 1'b1 || valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done2: done=%b v=%b expected 1 0", done_out, valid_out);
      end
   endtask

   initial begin
      nx_mode = 2'd0;
      nx_cur  = '0;
      test_reset();
      test_next();
      test_counter();
      test_lfsr();
      test_walk_backpressure();
      test_zero_len();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
